ad936x_tx_framer: RTL and testbench
===================================

// Module: ad936x_tx_framer
// PURPOSE
// - Parametrised TX framer for the AD936x LVDS/CMOS data port, single clock domain (clk = port data clock).
// - Buffers packed I/Q samples for N_CH channels in a sync FIFO and serialises each sample into 2*N_CH port words.
// - Generates tx_frame per 1R1T/2R2T framing and fills FIFO underflow with zeros or a repeat of the last sample.
// - Sits between the modem TX stream and the DDR/IO wrapper; fb_clk generation stays in the wrapper.
// PARAMETERS
// - SAMPLE_W     12  bits per I or Q word.
// - N_CH         1   channels per sample slot; legal values 1 or 2.
// - FIFO_DEPTH   16  input FIFO entries; power of 2, >= 4.
// - START_LEVEL  4   FIFO level required to leave IDLE; 1..FIFO_DEPTH.
// - CNT_W        16  underflow counter width.
// PORTS
// - clk            in   1                      port data clock.
// - rst            in   1                      synchronous, active-high reset.
// - enable         in   1                      run request.
// - uf_mode        in   1                      0 = zero-fill on underflow, 1 = repeat last sample.
// - clr_status     in   1                      clears uf_sticky and uf_count.
// - in_valid       in   1                      sample valid.
// - in_ready       out  1                      sample accepted when in_valid & in_ready.
// - in_data        in   2*N_CH*SAMPLE_W        ch k: I at [(2k+1)*W +: W], Q at [2k*W +: W].
// - p_d            out  SAMPLE_W               port word.
// - tx_frame       out  1                      frame strobe.
// - active         out  1                      high in RUN/DRAIN.
// - fifo_level     out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy.
// - uf_sticky      out  1                      underflow seen since last clear.
// - uf_count       out  CNT_W                  underflow slot count, saturating.
// BEHAVIOUR
// - Reset values: p_d=0, tx_frame=0, active=0, uf_sticky=0, uf_count=0, in_ready=0 in reset cycle; FIFO flushed.
//   Reset mid-slot aborts the slot with no completion.
// - in_ready = !fifo_full, registered from FIFO state. A push at full is refused even with a same-cycle pop.
//   Push and pop in the same cycle otherwise leave the level unchanged.
// - Slot: LAST = 2*N_CH-1; word w is ch(w/2) I for even w, Q for odd w.
//   tx_frame = 1 for w < N_CH, else 0 (1R1T: I=1, Q=0; 2R2T: ch0 I/Q=1, ch1 I/Q=0).
// - word_cnt runs 0..LAST and wraps to 0; each wrap is a slot boundary.
// - States (shared enum):
//   IDLE:  p_d=0, tx_frame=0, no pops.
//          -> RUN on enable && fifo_level >= START_LEVEL: that edge pops the FIFO, loads slot_reg, drives word 0, word_cnt=0.
//   RUN:   each edge drives word word_cnt+1 from slot_reg. At LAST the next edge is a slot boundary:
//          - FIFO non-empty: pop and drive word 0 of the new sample (gapless).
//          - FIFO empty: underflow. slot_reg <= 0 (uf_mode=0) or keep (uf_mode=1); uf_sticky=1; uf_count++ saturating at all-ones.
//          - enable=0 at boundary: -> IDLE, no pop, p_d=0, tx_frame=0.
//          - enable falls mid-slot: -> DRAIN.
//   DRAIN: finish the current slot unchanged, then -> IDLE without popping.
//          enable re-asserted in DRAIN: -> RUN at the boundary with normal pop rules.
// - Latency: sample popped at edge t puts ch0 I on p_d for cycle t..t+1. Output is registered, no combinational path from in_*.
// - clr_status together with a new underflow: the increment wins (uf_count=1, uf_sticky=1).
// - uf_mode is sampled only at slot boundaries.
// - "Last sample" after reset is all-zero.
// STRUCTURE
// - Package ad936x_pkg: typedef enum t_tx_framer_state {ST_IDLE, ST_RUN, ST_DRAIN}; typedef enum t_uf_mode {UF_ZERO, UF_REPEAT};
//   localparam AD936X_MAX_CH = 2.
// - Sub-module fifo_sync (WIDTH=2*N_CH*SAMPLE_W, DEPTH=FIFO_DEPTH; valid/ready both sides, level output).
// - Top: state machine, word_cnt, slot_reg, word mux, status counters.
// TESTING
// - N_CH=1: push 4 samples (I=0x123,Q=0x456 ...), enable=1 -> p_d 0x123,0x456,... with tx_frame 1,0,... gapless; active=1.
// - N_CH=2: push {c1I=0xA01,c1Q=0xA02,c0I=0x501,c0Q=0x502} x4 -> p_d 0x501,0x502,0xA01,0xA02; tx_frame 1,1,0,0.
// - Underflow: 4 samples then stop, uf_mode=0 -> zeros with correct tx_frame, uf_count increments per slot, uf_sticky=1;
//   repeat with uf_mode=1 -> last sample repeats.
// - Full: FIFO_DEPTH=16, enable=0, push 20 -> in_ready=0 after 16, fifo_level=16, no data loss on later drain.
// - Enable drop mid-slot at word 1 (N_CH=2) -> words 2,3 still sent, then p_d=0, tx_frame=0, level unchanged after slot.
// - rst asserted at word 1 of RUN -> next cycle p_d=0, tx_frame=0, fifo_level=0, uf_count=0, state IDLE.

Source files
------------

// File: rtl/ad936x_pkg.sv
// Shared types for the AD936x TX data-port framer.
package ad936x_pkg;
    localparam int AD936X_MAX_CH = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} t_tx_framer_state;
    typedef enum logic {UF_ZERO, UF_REPEAT} t_uf_mode;
endpackage

// File: rtl/ad936x_tx_framer_fifo_sync.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy output.
module fifo_sync #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      level_reg, level_next;
    logic             ready_reg;
    logic             push, pop;

    // ready comes only from registered state, so a push at full is refused even if a pop happens too
    assign push      = in_valid && ready_reg;
    assign out_valid = (level_reg != '0);
    assign pop       = out_ready && out_valid;
    assign in_ready  = ready_reg && !rst;
    assign out_data  = mem[rd_ptr_reg];
    assign level     = level_reg;

    always_comb begin
        level_next = level_reg;
        if (push && !pop)
            level_next = level_reg + 1'b1;
        else if (!push && pop)
            level_next = level_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr_reg] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
            ready_reg <= (level_next != FULL_LEVEL);
        end
    end
endmodule

// File: rtl/ad936x_tx_framer.sv
// AD936x TX framer: buffers packed I/Q samples and serialises each into 2*N_CH port
// words with tx_frame, filling FIFO underflow with zeros or the last sample.
module ad936x_tx_framer
    import ad936x_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int N_CH        = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 4,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           uf_mode,
    input  logic                           clr_status,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*N_CH*SAMPLE_W-1:0]     in_data,
    output logic [SAMPLE_W-1:0]            p_d,
    output logic                           tx_frame,
    output logic                           active,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           uf_sticky,
    output logic [CNT_W-1:0]               uf_count
);
    localparam int DATA_W = 2*N_CH*SAMPLE_W;
    localparam int LVL_W  = $clog2(FIFO_DEPTH)+1;
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);
    localparam logic [1:0] LAST = 2'(2*N_CH-1);

    t_tx_framer_state  state_reg;
    logic [1:0]        word_cnt_reg;
    logic [DATA_W-1:0] slot_reg;
    logic [SAMPLE_W-1:0] p_d_reg;
    logic              tx_frame_reg;
    logic              uf_sticky_reg;
    logic [CNT_W-1:0]  uf_count_reg;

    logic              fifo_valid, fifo_pop;
    logic [DATA_W-1:0] fifo_data, new_slot;
    logic              at_last, start, boundary_run, underflow;

    fifo_sync #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(fifo_valid),
        .out_ready(fifo_pop),
        .out_data (fifo_data),
        .level    (fifo_level)
    );

    // Word w carries ch(w/2): I (upper lane of the pair) for even w, Q for odd w.
    function automatic logic [SAMPLE_W-1:0] word_of(input logic [DATA_W-1:0] s, input logic [1:0] w);
        logic [SAMPLE_W-1:0] r;
        r = '0;
        for (int k = 0; k < 2*N_CH; k++)
            if (k == int'(w ^ 2'd1))
                r = s[k*SAMPLE_W +: SAMPLE_W];
        return r;
    endfunction

    assign at_last      = (word_cnt_reg == LAST);
    assign start        = (state_reg == ST_IDLE) && enable && (fifo_level >= START_LVL);
    assign boundary_run = (state_reg != ST_IDLE) && at_last && enable;
    assign fifo_pop     = start || (boundary_run && fifo_valid);
    assign underflow    = boundary_run && !fifo_valid;
    assign new_slot     = fifo_pop ? fifo_data :
                          (t_uf_mode'(uf_mode) == UF_REPEAT) ? slot_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            slot_reg     <= '0;
            p_d_reg      <= '0;
            tx_frame_reg <= 1'b0;
        end else if (start || boundary_run) begin
            state_reg    <= ST_RUN;
            word_cnt_reg <= '0;
            slot_reg     <= new_slot;
            p_d_reg      <= word_of(new_slot, 2'd0);
            tx_frame_reg <= 1'b1;
        end else if (state_reg == ST_IDLE || at_last) begin
            // idle, or a slot boundary reached with enable low
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            p_d_reg      <= '0;
            tx_frame_reg <= 1'b0;
        end else begin
            word_cnt_reg <= word_cnt_reg + 2'd1;
            p_d_reg      <= word_of(slot_reg, word_cnt_reg + 2'd1);
            tx_frame_reg <= (int'(word_cnt_reg + 2'd1) < N_CH);
            if (state_reg == ST_RUN && !enable)
                state_reg <= ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uf_sticky_reg <= 1'b0;
            uf_count_reg  <= '0;
        end else if (underflow) begin
            uf_sticky_reg <= 1'b1;
            if (clr_status)
                uf_count_reg <= CNT_W'(1);
            else if (uf_count_reg != '1)
                uf_count_reg <= uf_count_reg + 1'b1;
        end else if (clr_status) begin
            uf_sticky_reg <= 1'b0;
            uf_count_reg  <= '0;
        end
    end

    assign p_d       = p_d_reg;
    assign tx_frame  = tx_frame_reg;
    assign active    = (state_reg != ST_IDLE);
    assign uf_sticky = uf_sticky_reg;
    assign uf_count  = uf_count_reg;
endmodule

// File: tb/tb_ad936x_tx_framer.sv
// Directed + randomized bench for ad936x_tx_framer (2R2T, 16-deep FIFO).
module tb_ad936x_tx_framer;
    localparam int W      = 12;
    localparam int NCH    = 2;
    localparam int DW     = 2*NCH*W;
    localparam int DEPTH  = 16;

    logic          clk = 1'b0;
    logic          rst, enable, uf_mode, clr_status, in_valid;
    logic          in_ready, tx_frame, active, uf_sticky;
    logic [DW-1:0] in_data;
    logic [W-1:0]  p_d;
    logic [4:0]    fifo_level;
    logic [15:0]   uf_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [DW-1:0] pend[$];
    logic [W-1:0]  exp_d[$];
    bit            exp_f[$];

    always #5 clk = ~clk;

    ad936x_tx_framer #(
        .SAMPLE_W(W), .N_CH(NCH), .FIFO_DEPTH(DEPTH), .START_LEVEL(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .uf_mode(uf_mode), .clr_status(clr_status),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .p_d(p_d), .tx_frame(tx_frame), .active(active), .fifo_level(fifo_level),
        .uf_sticky(uf_sticky), .uf_count(uf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference word order: word w is channel w/2, I on even w and Q on odd w.
    function automatic logic [W-1:0] ref_word(input logic [DW-1:0] s, input int w);
        int ch;
        ch = w / 2;
        if (w % 2 == 0)
            return s[(2*ch+1)*W +: W];
        else
            return s[(2*ch)*W +: W];
    endfunction

    function automatic void add_sample(input logic [DW-1:0] s);
        for (int w = 0; w < 2*NCH; w++) begin
            exp_d.push_back(ref_word(s, w));
            exp_f.push_back(w < NCH);
        end
    endfunction

    task automatic push_one(input logic [DW-1:0] s, output bit acc);
        in_valid = 1'b1;
        in_data  = s;
        acc      = in_ready;
        if (acc)
            pend.push_back(s);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_rand(input int n, output int n_acc);
        logic [63:0] r;
        bit a;
        n_acc = 0;
        for (int k = 0; k < n; k++) begin
            r = {$urandom(), $urandom()};
            push_one(r[DW-1:0], a);
            if (a)
                n_acc++;
        end
    endtask

    // Check one word per cycle against exp_d/exp_f, then expect idle output.
    task automatic run_stream(input string tag, input int drop_at, input int clr_at, input int lvl0);
        int i;
        i = 0;
        while (exp_d.size() > 0) begin
            @(negedge clk);
            chk({tag, "_pd"}, 64'(p_d), 64'(exp_d.pop_front()));
            chk({tag, "_frame"}, 64'(tx_frame), 64'(exp_f.pop_front()));
            chk({tag, "_active"}, 64'(active), 64'd1);
            if (i == 0 && lvl0 >= 0)
                chk({tag, "_lvl0"}, 64'(fifo_level), 64'(lvl0));
            in_valid   = 1'b0;
            clr_status = (i == clr_at);
            if (i == drop_at)
                enable = 1'b0;
            i++;
        end
        clr_status = 1'b0;
        enable     = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_pd"}, 64'(p_d), 64'd0);
        chk({tag, "_idle_frame"}, 64'(tx_frame), 64'd0);
        chk({tag, "_idle_active"}, 64'(active), 64'd0);
    endtask

    initial begin
        int n_acc;
        bit a;
        logic [DW-1:0] s_last;
        logic [DW-1:0] s_e;

        rst = 1'b1; enable = 1'b0; uf_mode = 1'b0; clr_status = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_pd", 64'(p_d), 0);
        chk("rst_frame", 64'(tx_frame), 0);
        chk("rst_active", 64'(active), 0);
        chk("rst_level", 64'(fifo_level), 0);
        chk("rst_sticky", 64'(uf_sticky), 0);
        chk("rst_count", 64'(uf_count), 0);
        chk("rst_ready", 64'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 1);

        // A: gapless stream then zero-fill underflow
        push_one(48'hA01_A02_501_502, a);
        push_rand(3, n_acc);
        chk("A_level", 64'(fifo_level), 4);
        uf_mode = 1'b0;
        enable  = 1'b1;
        foreach (pend[k]) add_sample(pend[k]);
        pend.delete();
        add_sample('0);
        add_sample('0);
        run_stream("A", -1, -1, 3);
        chk("A_count", 64'(uf_count), 2);
        chk("A_sticky", 64'(uf_sticky), 1);
        chk("A_level_end", 64'(fifo_level), 0);

        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("clr_count", 64'(uf_count), 0);
        chk("clr_sticky", 64'(uf_sticky), 0);

        // B: repeat-last underflow; clear lands on the first underflow edge
        push_rand(4, n_acc);
        uf_mode = 1'b1;
        enable  = 1'b1;
        s_last  = pend[3];
        foreach (pend[k]) add_sample(pend[k]);
        pend.delete();
        add_sample(s_last);
        add_sample(s_last);
        run_stream("B", -1, 15, -1);
        chk("B_count", 64'(uf_count), 2);
        chk("B_sticky", 64'(uf_sticky), 1);

        // C: fill past full, refused push during first pop, full drain
        uf_mode = 1'b0;
        push_rand(20, n_acc);
        chk("C_accepted", 64'(n_acc), 16);
        chk("C_level", 64'(fifo_level), 16);
        chk("C_ready", 64'(in_ready), 0);
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 48'hDEAD_BEEF_0BAD;
        foreach (pend[k]) add_sample(pend[k]);
        pend.delete();
        run_stream("C", -1, -1, 15);
        chk("C_level_end", 64'(fifo_level), 0);
        chk("C_count", 64'(uf_count), 2);

        // D: enable falls while word 1 is on the port
        push_rand(8, n_acc);
        chk("D_level", 64'(fifo_level), 8);
        enable = 1'b1;
        add_sample(pend.pop_front());
        run_stream("D", 1, -1, 7);
        repeat (3) @(negedge clk);
        chk("D_level_after", 64'(fifo_level), 7);
        chk("D_pd_after", 64'(p_d), 0);

        // E: reset while word 1 of a slot is on the port
        enable = 1'b1;
        s_e = pend.pop_front();
        @(negedge clk);
        chk("E_w0", 64'(p_d), 64'(ref_word(s_e, 0)));
        @(negedge clk);
        chk("E_w1", 64'(p_d), 64'(ref_word(s_e, 1)));
        rst = 1'b1;
        @(negedge clk);
        chk("E_pd", 64'(p_d), 0);
        chk("E_frame", 64'(tx_frame), 0);
        chk("E_level", 64'(fifo_level), 0);
        chk("E_count", 64'(uf_count), 0);
        chk("E_active", 64'(active), 0);
        rst    = 1'b0;
        enable = 1'b0;
        pend.delete();
        @(negedge clk);
        chk("E_ready", 64'(in_ready), 1);
        chk("E_idle_pd", 64'(p_d), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
